// File: rtl/pipeline_ctrl_fsm_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } ctrl_state_e;

    localparam int MD_TIMEOUT_DEF = 64;

endpackage

// File: rtl/pipeline_ctrl_fsm_if.sv
// Hazard-unit bundle: pipeline status in, stall/flush controls out.
interface pipeline_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       RdE;
    logic             MemReadE;
    logic             PCSelectE;
    logic             MulDivE;
    logic             MdDone;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             MdStart;
    logic             MdTimeout;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output Rs1D, Rs2D, RdE, MemReadE, PCSelectE, MulDivE, MdDone,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  MdStart, MdTimeout, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, RdE, MemReadE, PCSelectE, MulDivE, MdDone,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output MdStart, MdTimeout, StallCount
    );
endinterface

// File: rtl/pipeline_ctrl_fsm_sat_counter.sv
// Saturating up-counter used for stall performance accounting.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pipeline_ctrl_fsm.sv
// Pipeline stall/flush controller with mul/div wait FSM and watchdog.
// Optional stall counter enabled by STALL_PERF_CNT_EN.
module pipeline_ctrl_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = 32
) (
    input logic                clk,
    input logic                reset,
    pipeline_ctrl_fsm_if.slave bus
);
    localparam int WD_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    ctrl_state_e     r_state;
    ctrl_state_e     w_next_state;
    logic [WD_W-1:0] r_wd;
    logic [WD_W-1:0] w_wd_next;
    logic            w_load_use;
    logic            w_stall_f;
    logic            w_stall_d;
    logic            w_stall_e;
    logic            w_flush_d;
    logic            w_flush_e;
    logic            w_flush_m;
    logic            w_md_start;
    logic            w_md_timeout;

    assign w_load_use = bus.MemReadE && (bus.RdE != 5'd0) &&
                        ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_wd    <= '0;
        end else begin
            r_state <= w_next_state;
            r_wd    <= w_wd_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wd_next    = r_wd;
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_stall_e    = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_flush_m    = 1'b0;
        w_md_start   = 1'b0;
        w_md_timeout = 1'b0;
        unique case (r_state)
            RUN: begin
                if (bus.MulDivE) begin
                    w_md_start   = 1'b1;
                    w_stall_f    = 1'b1;
                    w_stall_d    = 1'b1;
                    w_stall_e    = 1'b1;
                    w_flush_m    = 1'b1;
                    w_next_state = MD_WAIT;
                    w_wd_next    = '0;
                end else if (bus.PCSelectE) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (w_load_use) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end
            end
            MD_WAIT: begin
                if (bus.MdDone) begin
                    w_next_state = RUN;
                    w_wd_next    = '0;
                end else if (r_wd == WD_LAST) begin
                    w_md_timeout = 1'b1;
                    w_next_state = RUN;
                    w_wd_next    = '0;
                end else begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_stall_e = 1'b1;
                    w_flush_m = 1'b1;
                    w_wd_next = r_wd + 1'b1;
                end
            end
            default: begin
                w_next_state = RUN;
                w_wd_next    = '0;
            end
        endcase
        // Reset forces quiet outputs, so an abandoned wait never reports a timeout
        if (reset) begin
            w_stall_f    = 1'b0;
            w_stall_d    = 1'b0;
            w_stall_e    = 1'b0;
            w_flush_d    = 1'b0;
            w_flush_e    = 1'b0;
            w_flush_m    = 1'b0;
            w_md_start   = 1'b0;
            w_md_timeout = 1'b0;
        end
    end

    assign bus.StallF    = w_stall_f;
    assign bus.StallD    = w_stall_d;
    assign bus.StallE    = w_stall_e;
    assign bus.FlushD    = w_flush_d;
    assign bus.FlushE    = w_flush_e;
    assign bus.FlushM    = w_flush_m;
    assign bus.MdStart   = w_md_start;
    assign bus.MdTimeout = w_md_timeout;

`ifdef STALL_PERF_CNT_EN
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall_f),
        .o_count (bus.StallCount)
    );
`else
    assign bus.StallCount = {CNT_W{1'b0}};
`endif
endmodule
